// File: rtl/vga_rx_decoder.sv
// rtl/vga_rx_decoder.sv - VGA receive decoder: sync recovery, pixel coordinates, timing measurement and lock
module vga_rx_decoder #(
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int H_TOTAL     = 1344,
    parameter int H_START     = 296,
    parameter int H_ACTIVE    = 1024,
    parameter int V_TOTAL     = 806,
    parameter int V_START     = 35,
    parameter int V_ACTIVE    = 768,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] h_meas,
    output logic [11:0] v_meas,
    output logic        err_h,
    output logic        err_v
);
    localparam logic        HS_ACT = (HS_POL != 0);
    localparam logic        VS_ACT = (VS_POL != 0);
    localparam logic [11:0] H_TOT  = 12'(H_TOTAL);
    localparam logic [11:0] H_ST   = 12'(H_START);
    localparam logic [11:0] H_END  = 12'(H_START + H_ACTIVE);
    localparam logic [11:0] V_TOT  = 12'(V_TOTAL);
    localparam logic [11:0] V_ST   = 12'(V_START);
    localparam logic [11:0] V_END  = 12'(V_START + V_ACTIVE);
    localparam logic [7:0]  LF     = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    logic        hs_s0, hs_s1, vs_s0, vs_s1;
    logic [11:0] rgb_s0, rgb_s1;
    logic [11:0] hcnt, lcnt, hcnt_inc, lcnt_inc, v_cap, px_full, py_full;
    logic        hs_edge, vs_edge, h_bad, v_bad, h_seen, v_seen, saturated;
    logic        h_act, v_act;
    state_t      state, state_nx;
    logic [7:0]  good_cnt, good_nx;
    logic        ferr, ferr_nx;

    // Syncs are normalised to active-high; s1 holds the previous sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s0  <= 1'b0;
            hs_s1  <= 1'b0;
            vs_s0  <= 1'b0;
            vs_s1  <= 1'b0;
            rgb_s0 <= '0;
            rgb_s1 <= '0;
        end else begin
            hs_s0  <= (hs == HS_ACT);
            hs_s1  <= hs_s0;
            vs_s0  <= (vs == VS_ACT);
            vs_s1  <= vs_s0;
            rgb_s0 <= {r, g, b};
            rgb_s1 <= rgb_s0;
        end
    end

    assign hs_edge   = hs_s0 & ~hs_s1;
    assign vs_edge   = vs_s0 & ~vs_s1;
    assign hcnt_inc  = (hcnt == 12'hFFF) ? hcnt : hcnt + 12'd1;
    assign lcnt_inc  = (lcnt == 12'hFFF) ? lcnt : lcnt + 12'd1;
    assign v_cap     = hs_edge ? lcnt_inc : lcnt;
    assign h_bad     = hs_edge && h_seen && (hcnt_inc != H_TOT);
    assign v_bad     = vs_edge && v_seen && (v_cap != V_TOT);
    assign saturated = (hcnt == 12'hFFF) || (lcnt == 12'hFFF);

    // hcnt/lcnt after a clock describe the sample held in rgb_s1
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt   <= '0;
            lcnt   <= '0;
            h_meas <= '0;
            v_meas <= '0;
            h_seen <= 1'b0;
            v_seen <= 1'b0;
            err_h  <= 1'b0;
            err_v  <= 1'b0;
        end else begin
            err_h <= h_bad;
            err_v <= v_bad;
            if (hs_edge) begin
                hcnt   <= '0;
                h_meas <= hcnt_inc;
                h_seen <= 1'b1;
            end else begin
                hcnt <= hcnt_inc;
            end
            if (vs_edge) begin
                lcnt   <= '0;
                v_meas <= v_cap;
                v_seen <= 1'b1;
            end else if (hs_edge) begin
                lcnt <= lcnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            ferr     <= 1'b0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            ferr     <= ferr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        ferr_nx  = ferr | h_bad;
        case (state)
            UNLOCKED: begin
                if (vs_edge) begin
                    state_nx = ACQUIRE;
                    good_nx  = '0;
                    ferr_nx  = 1'b0;
                end
            end
            ACQUIRE: begin
                if (saturated) begin
                    state_nx = UNLOCKED;
                end else if (vs_edge) begin
                    ferr_nx = 1'b0;
                    if (!ferr && !h_bad && !v_bad) begin
                        good_nx = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 >= LF) state_nx = LOCKED;
                    end else begin
                        good_nx = '0;
                    end
                end
            end
            LOCKED: begin
                // Registered error pulses drop lock one cycle after they appear
                if (err_h || err_v || saturated) state_nx = UNLOCKED;
            end
            default: state_nx = UNLOCKED;
        endcase
    end

    assign locked  = (state == LOCKED);
    assign h_act   = (hcnt >= H_ST) && (hcnt < H_END);
    assign v_act   = (lcnt >= V_ST) && (lcnt < V_END);
    assign px_full = hcnt - H_ST;
    assign py_full = lcnt - V_ST;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
        end else begin
            pix_valid   <= locked && h_act && v_act;
            frame_start <= locked && (hcnt == H_ST) && (lcnt == V_ST);
            pix_x       <= px_full[10:0];
            pix_y       <= py_full[10:0];
            pix_rgb     <= rgb_s1;
        end
    end
endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb/tb_vga_rx_decoder.sv - directed bench for vga_rx_decoder on a reduced timing grid
module tb_vga_rx_decoder;
    localparam int HT = 10, HSW = 2, HST = 3, HACT = 6;
    localparam int VT = 12, VST = 3, VACT = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hs0, vs0, hs1, vs1;
    logic [3:0]  r, g, b;
    logic        pv0, fs0, lk0, eh0, ev0, pv1, fs1, lk1, eh1, ev1;
    logic [10:0] px0, py0, px1, py1;
    logic [11:0] prgb0, prgb1, hm0, vm0, hm1, vm1;

    vga_rx_decoder #(.HS_POL(0), .VS_POL(0), .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HACT),
                     .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VACT), .LOCK_FRAMES(2)) dut0 (
        .clk(clk), .rst(rst), .hs(hs0), .vs(vs0), .r(r), .g(g), .b(b),
        .pix_valid(pv0), .pix_x(px0), .pix_y(py0), .pix_rgb(prgb0), .frame_start(fs0),
        .locked(lk0), .h_meas(hm0), .v_meas(vm0), .err_h(eh0), .err_v(ev0));

    vga_rx_decoder #(.HS_POL(1), .VS_POL(1), .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HACT),
                     .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VACT), .LOCK_FRAMES(2)) dut1 (
        .clk(clk), .rst(rst), .hs(hs1), .vs(vs1), .r(r), .g(g), .b(b),
        .pix_valid(pv1), .pix_x(px1), .pix_y(py1), .pix_rgb(prgb1), .frame_start(fs1),
        .locked(lk1), .h_meas(hm1), .v_meas(vm1), .err_h(eh1), .err_v(ev1));

    typedef struct {
        int          l;
        int          c;
        logic [11:0] rgb;
        logic        valid;
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [10:0] x;
        logic [10:0] y;
        logic [11:0] rgb;
        logic        fs;
    } obs_t;

    vec_t tbl[9];
    obs_t obs0[VT][HT];
    obs_t obs1[VT][HT];

    int checks = 0, errors = 0;
    int cyc = 0;
    int d1l = -1, d1c = 0, d2l = -1, d2c = 0;
    int eh_cnt = 0, ev_cnt = 0, pv_cnt = 0, fs_cnt = 0;
    int eh_cyc = 0, fall_cyc = 0, rise_cyc = 0, rise_vs = 0, last_vs_cyc = 0;
    logic [11:0] hm_at_err = '0;
    logic prev_lk = 1'b0, prev_vs = 1'b0;
    logic rec_lk0, rec_lk1;
    logic [11:0] rec_vm0, rec_vm1, rec_hm0, rec_hm1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] rgb_at(input int l, input int c);
        for (int i = 0; i < 9; i++)
            if (tbl[i].l == l && tbl[i].c == c) return tbl[i].rgb;
        return 12'h000;
    endfunction

    // Drive one sample; outputs seen after the edge belong to the sample two ticks back
    task automatic tick(input logic hs_a, input logic vs_a, input logic [11:0] rgb,
                        input int l, input int c);
        hs0 = ~hs_a;
        vs0 = ~vs_a;
        hs1 = hs_a;
        vs1 = vs_a;
        {r, g, b} = rgb;
        @(posedge clk);
        #1;
        cyc++;
        if (vs_a && !prev_vs) last_vs_cyc = cyc;
        prev_vs = vs_a;
        if (d2l >= 0) begin
            obs0[d2l][d2c] = '{pv0, px0, py0, prgb0, fs0};
            obs1[d2l][d2c] = '{pv1, px1, py1, prgb1, fs1};
        end
        d2l = d1l;
        d2c = d1c;
        d1l = l;
        d1c = c;
        if (eh0) begin
            eh_cnt++;
            eh_cyc = cyc;
            hm_at_err = hm0;
        end
        if (ev0) ev_cnt++;
        if (pv0) pv_cnt++;
        if (fs0) fs_cnt++;
        if (prev_lk && !lk0) fall_cyc = cyc;
        if (!prev_lk && lk0) begin
            rise_cyc = cyc;
            rise_vs  = last_vs_cyc;
        end
        prev_lk = lk0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_dut0"}, 64'({pv0, px0, py0, prgb0, fs0, lk0, hm0, vm0, eh0, ev0}), 64'd0);
        check({name, "_dut1"}, 64'({pv1, px1, py1, prgb1, fs1, lk1, hm1, vm1, eh1, ev1}), 64'd0);
    endtask

    task automatic run_frame(input int vs_off, input int short_l, input int rst_l, input bit vs_on);
        int   clen;
        logic va;
        for (int l = 0; l < VT; l++) begin
            clen = (l == short_l) ? HT - 1 : HT;
            for (int c = 0; c < clen; c++) begin
                va = vs_on && ((l == 0 && c >= vs_off) || l == 1 || (l == 2 && c < vs_off));
                if (l == rst_l && c == 5) rst = 1'b1;
                tick(c < HSW, va, rgb_at(l, c), l, c);
                if (rst) begin
                    rst = 1'b0;
                    check_zero("mid_reset");
                end
                if (l == 1 && c == 0) begin
                    rec_lk0 = lk0;
                    rec_lk1 = lk1;
                    rec_vm0 = vm0;
                    rec_vm1 = vm1;
                    rec_hm0 = hm0;
                    rec_hm1 = hm1;
                end
            end
        end
    endtask

    initial begin
        tbl[0] = '{3, 3, 12'hF00, 1'b1, 11'd0,     11'd0,     1'b1};
        tbl[1] = '{9, 8, 12'h00F, 1'b1, 11'd5,     11'd6,     1'b0};
        tbl[2] = '{3, 2, 12'h123, 1'b0, 11'h7FF,   11'd0,     1'b0};
        tbl[3] = '{2, 3, 12'h456, 1'b0, 11'd0,     11'h7FF,   1'b0};
        tbl[4] = '{3, 9, 12'h789, 1'b0, 11'd6,     11'd0,     1'b0};
        tbl[5] = '{10, 3, 12'hABC, 1'b0, 11'd0,    11'd7,     1'b0};
        tbl[6] = '{6, 5, 12'h5A5, 1'b1, 11'd2,     11'd3,     1'b0};
        tbl[7] = '{4, 3, 12'h0F0, 1'b1, 11'd0,     11'd1,     1'b0};
        tbl[8] = '{3, 4, 12'h111, 1'b1, 11'd1,     11'd0,     1'b0};

        rst = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 12'h000, -1, 0);
        check_zero("reset");
        rst = 1'b0;

        // Nominal acquisition: vs edges 2 and 3 close the clean frames
        run_frame(1, -1, -1, 1'b1);
        check("f1_locked", 64'(rec_lk0), 64'd0);
        run_frame(1, -1, -1, 1'b1);
        check("f2_locked", 64'(rec_lk0), 64'd0);
        check("f2_h_meas", 64'(rec_hm0), 64'(HT));
        check("f2_v_meas", 64'(rec_vm0), 64'(VT));
        run_frame(1, -1, -1, 1'b1);
        check("f3_locked", 64'(rec_lk0), 64'd1);
        check("f3_locked_pol", 64'(rec_lk1), 64'd1);
        check("lock_rise_delay", 64'(rise_cyc - rise_vs), 64'd1);

        pv_cnt = 0;
        fs_cnt = 0;
        run_frame(1, -1, -1, 1'b1);
        check("nominal_err_h", 64'(eh_cnt), 64'd0);
        check("nominal_err_v", 64'(ev_cnt), 64'd0);
        check("valid_per_frame", 64'(pv_cnt), 64'(HACT * VACT));
        check("frame_start_per_frame", 64'(fs_cnt), 64'd1);
        check("f4_h_meas_pol", 64'(rec_hm1), 64'(HT));
        for (int i = 0; i < 9; i++) begin
            for (int d = 0; d < 2; d++) begin
                obs_t o;
                o = (d == 0) ? obs0[tbl[i].l][tbl[i].c] : obs1[tbl[i].l][tbl[i].c];
                check($sformatf("tbl%0d_dut%0d_valid", i, d), 64'(o.valid), 64'(tbl[i].valid));
                check($sformatf("tbl%0d_dut%0d_x", i, d), 64'(o.x), 64'(tbl[i].x));
                check($sformatf("tbl%0d_dut%0d_y", i, d), 64'(o.y), 64'(tbl[i].y));
                check($sformatf("tbl%0d_dut%0d_rgb", i, d), 64'(o.rgb), 64'(tbl[i].rgb));
                check($sformatf("tbl%0d_dut%0d_fs", i, d), 64'(o.fs), 64'(tbl[i].fs));
            end
        end

        // Coincident hs/vs edges
        run_frame(0, -1, -1, 1'b1);
        check("coinc_in_locked", 64'(rec_lk0), 64'd1);
        check("coinc_in_v_meas", 64'(rec_vm0), 64'(VT));
        run_frame(1, -1, -1, 1'b1);
        check("coinc_out_v_meas", 64'(rec_vm0), 64'(VT));
        check("coinc_out_v_meas_pol", 64'(rec_vm1), 64'(VT));
        check("coinc_locked", 64'(rec_lk0), 64'd1);
        check("coinc_locked_pol", 64'(rec_lk1), 64'd1);
        check("coinc_err_v", 64'(ev_cnt), 64'd0);

        // Short line while locked
        eh_cnt = 0;
        run_frame(1, 5, -1, 1'b1);
        check("short_err_h_count", 64'(eh_cnt), 64'd1);
        check("short_h_meas", 64'(hm_at_err), 64'(HT - 1));
        check("short_unlock_delay", 64'(fall_cyc - eh_cyc), 64'd1);
        check("short_locked_after", 64'(lk0), 64'd0);
        run_frame(1, -1, -1, 1'b1);
        check("short_relock_f1", 64'(rec_lk0), 64'd0);
        run_frame(1, -1, -1, 1'b1);
        check("short_relock_f2", 64'(rec_lk0), 64'd0);
        run_frame(1, -1, -1, 1'b1);
        check("short_relock_f3", 64'(rec_lk0), 64'd1);
        check("short_err_h_total", 64'(eh_cnt), 64'd1);

        // Reset mid-frame; first edges afterwards are exempt
        eh_cnt = 0;
        ev_cnt = 0;
        run_frame(1, -1, 6, 1'b1);
        run_frame(1, -1, -1, 1'b1);
        check("rst_relock_f1", 64'(rec_lk0), 64'd0);
        run_frame(1, -1, -1, 1'b1);
        check("rst_relock_f2", 64'(rec_lk0), 64'd0);
        run_frame(1, -1, -1, 1'b1);
        check("rst_relock_f3", 64'(rec_lk0), 64'd1);
        check("rst_err_h", 64'(eh_cnt), 64'd0);
        check("rst_err_v", 64'(ev_cnt), 64'd0);

        // Lost vsync until the line counter saturates
        run_frame(1, -1, -1, 1'b0);
        check("novs_still_locked", 64'(rec_lk0), 64'd1);
        repeat (343) run_frame(1, -1, -1, 1'b0);
        check("novs_unlocked", 64'(lk0), 64'd0);
        check("novs_unlocked_pol", 64'(lk1), 64'd0);
        check("novs_err_v", 64'(ev_cnt), 64'd0);
        run_frame(1, -1, -1, 1'b1);
        check("restore_v_meas_sat", 64'(rec_vm0), 64'hFFF);
        check("restore_err_v", 64'(ev_cnt), 64'd1);
        check("restore_f1_locked", 64'(rec_lk0), 64'd0);
        run_frame(1, -1, -1, 1'b1);
        check("restore_f2_locked", 64'(rec_lk0), 64'd0);
        check("restore_f2_v_meas", 64'(rec_vm0), 64'(VT));
        run_frame(1, -1, -1, 1'b1);
        check("restore_f3_locked", 64'(rec_lk0), 64'd1);
        check("restore_f3_locked_pol", 64'(rec_lk1), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_rx_decoder.md
# vga_rx_decoder

Receive-side decoder for the board's VGA output interface (1024x768 @ 60 Hz, 65 MHz pixel clock). It samples the same `hs`/`vs`/`r`/`g`/`b` bundle that `top_vga` drives and rebuilds pixel coordinates, an active-video qualifier and captured pixel colour. It also measures line and frame lengths and reports lock and timing errors. It is used in loopback self-checking benches and as an on-chip monitor for the pong video path.

## Interface
Parameters:
- `HS_POL`, default 0: hsync assertion level (0 = active low).
- `VS_POL`, default 0: vsync assertion level.
- `H_TOTAL`, default 1344: expected clocks per line.
- `H_START`, default 296: clocks from hsync leading edge to the first active pixel.
- `H_ACTIVE`, default 1024: active pixels per line.
- `V_TOTAL`, default 806: expected lines per frame.
- `V_START`, default 35: line count (hsync edges since the vsync edge) of the first active line.
- `V_ACTIVE`, default 768: active lines per frame.
- `LOCK_FRAMES`, default 2: consecutive clean frames required to assert lock.

Ports:
- `clk`, in, 1: pixel clock, 65 MHz.
- `rst`, in, 1: reset, synchronous, active-high.
- `hs`, `vs`, in, 1 each: sync inputs.
- `r`, `g`, `b`, in, 4 each: colour inputs.
- `pix_valid`, out, 1: active pixel, asserted only while locked.
- `pix_x`, out, 11: active column, 0..H_ACTIVE-1.
- `pix_y`, out, 11: active row, 0..V_ACTIVE-1.
- `pix_rgb`, out, 12: {r,g,b} of that pixel.
- `frame_start`, out, 1: one-cycle pulse aligned with pixel (0,0) while locked.
- `locked`, out, 1: timing lock.
- `h_meas`, out, 12: length of the last complete line.
- `v_meas`, out, 12: line count of the last complete frame.
- `err_h`, `err_v`, out, 1 each: one-cycle mismatch pulses.

## Operation
- **Stage 0 (input register):** `hs`, `vs` and rgb are registered. Polarity is normalised with `HS_POL`/`VS_POL`. A leading edge is the transition from inactive to asserted between consecutive stage-0 samples.
- **Horizontal counter `hcnt` (12 bit):**
  - On an hs edge, `hcnt` is set to 0 and `h_meas` is set to `hcnt`+1.
  - Otherwise `hcnt` increments and saturates at 4095.
  - `err_h` pulses on an hs edge when `h_meas` differs from H_TOTAL. The first hs edge after reset is exempt (flag `h_seen`).
- **Line counter `lcnt` (12 bit):**
  - On an hs edge, `lcnt` increments and saturates at 4095.
  - On a vs edge, `lcnt` is set to 0 and `v_meas` is set to `lcnt`. If an hs edge occurs in the same cycle, `v_meas` is set to `lcnt`+1 and `lcnt` is still set to 0; vs wins.
  - `err_v` pulses on a vs edge when the captured value differs from V_TOTAL. The first vs edge after reset is exempt.
- **Lock state machine:** states UNLOCKED, ACQUIRE, LOCKED; counter `good_cnt`.
  - In UNLOCKED, the first vs edge moves to ACQUIRE, clears `good_cnt` and clears the frame error flag `ferr`.
  - `ferr` is set by any `err_h` in the frame.
  - In ACQUIRE, at each vs edge: if the frame was clean (`!ferr && !err_v`), `good_cnt` increments; otherwise `good_cnt` is set to 0. `ferr` is then cleared. When `good_cnt` reaches LOCK_FRAMES, move to LOCKED.
  - In LOCKED, any `err_h` or `err_v` moves to UNLOCKED in the next cycle.
  - Saturation of `hcnt` or `lcnt` also forces UNLOCKED, covering lost sync.
- **Active window:** the pixel is active when H_START <= `hcnt` < H_START+H_ACTIVE and V_START <= `lcnt` < V_START+V_ACTIVE.
  - `pix_x` = `hcnt`-H_START.
  - `pix_y` = `lcnt`-V_START.
  - Width rule: both subtractions are 12 bit, truncated to 11 bit.
- **Output register (stage 1):** when not locked, `pix_valid` = 0 and `frame_start` = 0, while `pix_x`, `pix_y` and `pix_rgb` keep tracking the counters.

## Timing
- **Reset values:** all outputs are 0, state is UNLOCKED, `hcnt` = `lcnt` = 0, and `h_seen` and `v_seen` are cleared.
- **Reset mid-frame:** everything returns to reset values in the next cycle. Lock is re-acquired only after the full LOCK_FRAMES sequence.
- **Latency:** a pixel sampled on `r`/`g`/`b` at edge N appears on `pix_*` after edge N+2, aligned with its `pix_valid`.
- **Sync edges:** an hs/vs input change at edge N is detected at N+1. `h_meas`, `v_meas`, `err_h` and `err_v` update at N+2.
- **Lock timing:** `locked` rises in the cycle after the vs edge that completes LOCK_FRAMES clean frames. It falls in the cycle after an error pulse.
- **Sync-edge counting:** a sync held asserted for many cycles counts as one edge only. Glitches back to inactive produce a new edge on re-assertion.

## Test plan
- **Nominal lock:** drive 4 nominal XGA frames -> `h_meas`=1344 and `v_meas`=806 from the second frame; `err_*` never pulse; `locked` rises after the 3rd vs edge (vs edges 2 and 3 close the clean frames).
- **Pixel mapping:** while locked, drive rgb=0xF00 only at timing pixel (0,0) and 0x00F at (1023,767) -> `pix_valid`=1 with x=0,y=0,`pix_rgb`=0xF00 and `frame_start`=1, two cycles later; 0x00F at x=1023,y=767; exactly 786432 `pix_valid` cycles per frame.
- **Short line:** shorten one line to 1343 while locked -> `h_meas`=1343, one `err_h` pulse, `locked`=0 next cycle; relock after 2 further clean frames.
- **Lost sync:** stop vsync -> `lcnt` saturates at 4095 and `locked` drops; restoring sync relocks after 2 clean frames.
- **Reset mid-frame:** assert `rst` one cycle at line 400 -> all outputs 0 next cycle; `err_*` stay silent on the first hs/vs edges after reset.
- **Polarity and coincident edges:** run with `HS_POL`=`VS_POL`=1 and inverted stimulus, plus a frame where hs and vs edges coincide -> identical results, with `v_meas`=806.
